// File: rtl/frac_div_gen.sv
`timescale 1ns/1ps
// Fractional clock-enable generator: a Width-bit phase accumulator that emits a
// one-cycle pulse on every carry out, giving an average rate of f_in*Incr/2^Width.
module frac_div_gen #(
    parameter int unsigned Width = 8,
    parameter int unsigned Incr  = 1
) (
    input  logic in,
    input  logic rst_n,
    output logic out
);

    localparam logic [Width-1:0] IncrW = Width'(Incr);

    logic [Width-1:0] acc_q, acc_d;
    logic             out_q, out_d;

    // The pulse is the carry of the Width+1 bit sum, not the accumulator MSB.
    always_comb begin
        {out_d, acc_d} = {1'b0, acc_q} + {1'b0, IncrW};
    end

    always_ff @(posedge in or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            out_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_frac_div_gen.sv
`timescale 1ns/1ps
// Bench for frac_div_gen: several parameterisations share one clock and reset and
// are compared each cycle against the ceil(k*2^Width/Incr) pulse-placement rule.
module tb_frac_div_gen;

    localparam int NI = 7;
    localparam int unsigned CfgW [NI] = '{3, 22, 3, 3, 3, 8, 32};
    localparam int unsigned CfgI [NI] = '{1, 19327, 4, 7, 0, 173, 32'hDEADBEEF};

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NI-1:0]   outs;
    int              vectors = 0;
    int              miscompares = 0;
    longint unsigned edges = 0;
    longint          rise0[$], fall0[$], rise1[$];

    always #20 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        frac_div_gen #(
            .Width(CfgW[g]),
            .Incr (CfgI[g])
        ) u_dut (
            .in   (clk),
            .rst_n(rst_n),
            .out  (outs[g])
        );
    end

    // Rising edges of the clock seen since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    always @(posedge outs[0]) rise0.push_back($time);
    always @(negedge outs[0]) fall0.push_back($time);
    always @(posedge outs[1]) rise1.push_back($time);

    // Edge e carries iff floor(e*Incr/2^W) steps, i.e. e is some ceil(k*2^W/Incr).
    function automatic logic model_out(int i, longint unsigned e);
        longint unsigned m, inc;
        m   = 64'd1 << CfgW[i];
        inc = longint'(CfgI[i]);
        if (e == 0) return 1'b0;
        return ((e * inc) / m) != (((e - 1) * inc) / m);
    endfunction

    task automatic test_reset_state();
        #1 rst_n = 1'b0;
        #4;
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (outs[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state inst%0d: out=%b want 0", i, outs[i]);
            end
        end
        rise0.delete(); fall0.delete(); rise1.delete();
        #5 rst_n = 1'b1;
    endtask

    task automatic test_example_timing();
        for (int c = 0; c < 440; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (outs[i] !== model_out(i, edges)) begin
                    miscompares++;
                    $display("FAIL timing_stream inst%0d edge %0d: out=%b want %b",
                             i, edges, outs[i], model_out(i, edges));
                end
            end
        end
        vectors++;
        if (rise0.size() < 2 || fall0.size() < 1) begin
            miscompares++;
            $display("FAIL w3_rise_count: rises=%0d falls=%0d want >=2 and >=1",
                     rise0.size(), fall0.size());
        end else if (rise0[0] != 300 || rise0[1] != 620 || fall0[0] != 340) begin
            miscompares++;
            $display("FAIL w3_rise_times: rise %0d,%0d fall %0d want 300,620 fall 340",
                     rise0[0], rise0[1], fall0[0]);
        end
        vectors++;
        if (rise1.size() < 2) begin
            miscompares++;
            $display("FAIL w22_rise_count: rises=%0d want >=2", rise1.size());
        end else if (rise1[0] != 8700 || rise1[1] != 17380) begin
            miscompares++;
            $display("FAIL w22_rise_times: %0d,%0d want 8700,17380", rise1[0], rise1[1]);
        end
    endtask

    task automatic test_boundaries();
        int ones7;
        @(negedge clk);
        #5 rst_n = 1'b0;
        @(negedge clk);
        #5 rst_n = 1'b1;
        ones7 = 0;
        for (int e = 1; e <= 100; e++) begin
            @(negedge clk);
            vectors++;
            if (outs[2] !== ((e % 2) == 0)) begin
                miscompares++;
                $display("FAIL half_incr edge %0d: out=%b want %b", e, outs[2], (e % 2) == 0);
            end
            vectors++;
            if (outs[4] !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_incr edge %0d: out=%b want 0", e, outs[4]);
            end
            if (e <= 16) ones7 += int'(outs[3]);
            if (e == 1 || e == 9) begin
                vectors++;
                if (outs[3] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL incr7_gap edge %0d: out=%b want 0", e, outs[3]);
                end
            end
        end
        vectors++;
        if (ones7 != 14) begin
            miscompares++;
            $display("FAIL incr7_density: %0d pulses in 16 edges want 14", ones7);
        end
    endtask

    task automatic test_mid_reset();
        int first;
        @(negedge clk);
        #5 rst_n = 1'b0;
        @(negedge clk);
        #5 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #10 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (outs[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL async_reset inst%0d: out=%b want 0", i, outs[i]);
            end
        end
        @(negedge clk);
        #5 rst_n = 1'b1;
        first = 0;
        for (int e = 1; e <= 20 && first == 0; e++) begin
            @(negedge clk);
            if (outs[0] === 1'b1) first = e;
        end
        vectors++;
        if (first != 8) begin
            miscompares++;
            $display("FAIL phase_lost: first pulse on edge %0d want 8", first);
        end
    endtask

    task automatic test_hold_reset();
        @(negedge clk);
        #5 rst_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (outs[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold_reset cycle %0d inst%0d: out=%b want 0", c, i, outs[i]);
                end
            end
        end
        #5 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (outs[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL release_edge1 inst%0d: out=%b want 0", i, outs[i]);
            end
        end
    endtask

    task automatic test_random_runs();
        int run_len;
        for (int r = 0; r < 6; r++) begin
            @(posedge clk);
            #($urandom_range(1, 15)) rst_n = 1'b0;
            #1;
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (outs[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_async_reset round %0d inst%0d: out=%b want 0",
                             r, i, outs[i]);
                end
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #($urandom_range(1, 15)) rst_n = 1'b1;
            run_len = int'($urandom_range(20, 400));
            for (int c = 0; c < run_len; c++) begin
                @(negedge clk);
                for (int i = 0; i < NI; i++) begin
                    vectors++;
                    if (outs[i] !== model_out(i, edges)) begin
                        miscompares++;
                        $display("FAIL rand_stream round %0d inst%0d edge %0d: out=%b want %b",
                                 r, i, edges, outs[i], model_out(i, edges));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset_state();
        test_example_timing();
        test_boundaries();
        test_mid_reset();
        test_hold_reset();
        test_random_runs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
